// File: rtl/game_pkg.sv
// Game-level types: object identifiers, pixel-index geometry, circle colours
// and the fetcher FSM state type.
package game_pkg;

  localparam int unsigned MAP_H_WIDTH = 7;
  localparam int unsigned MAP_V_WIDTH = 7;
  localparam int unsigned PIX_IDX_W   = MAP_H_WIDTH + MAP_V_WIDTH;

  typedef enum logic [2:0] {
    MAP         = 3'd0,
    CAR1        = 3'd1,
    CAR2        = 3'd2,
    BAR         = 3'd3,
    CAR1_CIRCLE = 3'd4,
    CAR2_CIRCLE = 3'd5
  } ObjectID;

  localparam logic [23:0] CAR1_CIRCLE_COLOR = 24'hFF2020;
  localparam logic [23:0] CAR2_CIRCLE_COLOR = 24'h2020FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sram_pkg.sv
// SRAM memory map: word-address bases of each sprite/bitmap object.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 20;

  localparam logic [SRAM_ADDR_W-1:0] OBJ_BASE_MAP  = 20'h00000;
  localparam logic [SRAM_ADDR_W-1:0] OBJ_BASE_CAR1 = 20'h04000;
  localparam logic [SRAM_ADDR_W-1:0] OBJ_BASE_CAR2 = 20'h05000;
  localparam logic [SRAM_ADDR_W-1:0] OBJ_BASE_BAR  = 20'h06000;

endpackage

// File: rtl/Rgb565To888.sv
// RGB565 to RGB888 expansion by MSB replication, so full-scale stays full-scale.
module Rgb565To888 (
  input  logic [15:0] rgb565_i,
  output logic [23:0] rgb888_o
);

  logic [4:0] r5;
  logic [5:0] g6;
  logic [4:0] b5;

  assign r5 = rgb565_i[15:11];
  assign g6 = rgb565_i[10:5];
  assign b5 = rgb565_i[4:0];

  assign rgb888_o = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};

endmodule

// File: rtl/pixel_fetcher.sv
// Fetches one pixel per request: circles come from constants, other objects
// from SRAM. Define PIXEL_FETCHER_TIMEOUT_EN to abandon SRAM reads after 255 cycles.
module pixel_fetcher
  import game_pkg::*;
  import sram_pkg::*;
(
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_pix_valid,
  output logic                          o_pix_ready,
  input  ObjectID                       i_object_id,
  input  logic [PIX_IDX_W-1:0]          i_object_pixel_index,
  output logic                          o_sram_req,
  output logic [SRAM_ADDR_W-1:0]        o_sram_addr,
  input  logic                          i_sram_ack,
  input  logic [15:0]                   i_sram_rdata,
  output logic                          o_rgb_valid,
  input  logic                          i_rgb_ready,
  output logic [23:0]                   o_rgb
);

  fetch_state_e           state_q, state_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]            rgb_q, rgb_d;
  logic [23:0]            rdata_rgb888;
  logic [SRAM_ADDR_W-1:0] base_addr;

`ifdef PIXEL_FETCHER_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
`endif

  Rgb565To888 u_rgb565_to_888 (
    .rgb565_i (i_sram_rdata),
    .rgb888_o (rdata_rgb888)
  );

  always_comb begin
    base_addr = '0;
    case (i_object_id)
      MAP:     base_addr = OBJ_BASE_MAP;
      CAR1:    base_addr = OBJ_BASE_CAR1;
      CAR2:    base_addr = OBJ_BASE_CAR2;
      BAR:     base_addr = OBJ_BASE_BAR;
      default: base_addr = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rgb_d   = rgb_q;
`ifdef PIXEL_FETCHER_TIMEOUT_EN
    cnt_d   = 8'd0;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_pix_valid) begin
          case (i_object_id)
            CAR1_CIRCLE: begin
              rgb_d   = CAR1_CIRCLE_COLOR;
              state_d = OUT;
            end
            CAR2_CIRCLE: begin
              rgb_d   = CAR2_CIRCLE_COLOR;
              state_d = OUT;
            end
            MAP, CAR1, CAR2, BAR: begin
              addr_d  = base_addr + SRAM_ADDR_W'(i_object_pixel_index);
              state_d = REQ;
            end
            // Unknown IDs resolve to black without touching SRAM.
            default: begin
              rgb_d   = 24'h000000;
              state_d = OUT;
            end
          endcase
        end
      end
      REQ: begin
        if (i_sram_ack) begin
          rgb_d   = rdata_rgb888;
          state_d = OUT;
        end
`ifdef PIXEL_FETCHER_TIMEOUT_EN
        else if (cnt_q == 8'd254) begin
          // 255th cycle without ack: give up and emit black.
          rgb_d   = 24'h000000;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      OUT: begin
        if (i_rgb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rgb_q   <= '0;
`ifdef PIXEL_FETCHER_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rgb_q   <= rgb_d;
`ifdef PIXEL_FETCHER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign o_pix_ready = (state_q == IDLE);
  assign o_sram_req  = (state_q == REQ);
  assign o_sram_addr = addr_q;
  assign o_rgb_valid = (state_q == OUT);
  assign o_rgb       = rgb_q;

endmodule

// File: tb/tb_pixel_fetcher.sv
// Directed plus randomized bench for pixel_fetcher against a behavioural model.
module tb_pixel_fetcher;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic        pix_ready;
  ObjectID     obj_id;
  logic [13:0] obj_idx;
  logic        sram_req;
  logic [19:0] sram_addr;
  logic        sram_ack;
  logic [15:0] sram_rdata;
  logic        rgb_valid;
  logic        rgb_ready;
  logic [23:0] rgb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pixel_fetcher dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_pix_valid          (pix_valid),
    .o_pix_ready          (pix_ready),
    .i_object_id          (obj_id),
    .i_object_pixel_index (obj_idx),
    .o_sram_req           (sram_req),
    .o_sram_addr          (sram_addr),
    .i_sram_ack           (sram_ack),
    .i_sram_rdata         (sram_rdata),
    .o_rgb_valid          (rgb_valid),
    .i_rgb_ready          (rgb_ready),
    .o_rgb                (rgb)
  );

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_is_sram(input int oid);
    return oid >= 0 && oid <= 3;
  endfunction

  function automatic int model_base(input int oid);
    case (oid)
      0: return 'h00000;
      1: return 'h04000;
      2: return 'h05000;
      3: return 'h06000;
      default: return 0;
    endcase
  endfunction

  function automatic int model_rgb(input int oid, input int p);
    int r, g, b;
    if (oid == 4) return 'hFF2020;
    if (oid == 5) return 'h2020FF;
    if (!model_is_sram(oid)) return 0;
    r = (p / 2048) % 32;
    g = (p / 32) % 64;
    b = p % 32;
    return (r * 8 + r / 4) * 65536 + (g * 4 + g / 16) * 256 + (b * 8 + b / 4);
  endfunction

  // Starts and ends on a falling edge with the DUT idle.
  task automatic run_txn(input int oid, input int pidx, input int delay, input int rdata,
                         input int hold);
    int exp_addr;
    int exp_rgb;
    logic [2:0] id3;
    exp_addr = (model_base(oid) + pidx) % (1 << 20);
    exp_rgb  = model_rgb(oid, rdata);
    id3      = oid[2:0];
    check("pix_ready_idle", 24'(pix_ready), 24'd1);
    pix_valid = 1'b1;
    obj_id    = ObjectID'(id3);
    obj_idx   = pidx[13:0];
    @(negedge clk);
    pix_valid = 1'b0;
    if (model_is_sram(oid)) begin
      check("req_asserted", 24'(sram_req), 24'd1);
      check("req_addr", 24'(sram_addr), 24'(exp_addr));
      check("pix_ready_req", 24'(pix_ready), 24'd0);
      check("rgb_valid_req", 24'(rgb_valid), 24'd0);
      for (int k = 0; k < delay; k++) begin
        @(negedge clk);
        check("req_held", 24'(sram_req), 24'd1);
        check("addr_stable", 24'(sram_addr), 24'(exp_addr));
      end
      sram_ack   = 1'b1;
      sram_rdata = rdata[15:0];
      @(negedge clk);
      sram_ack   = 1'b0;
    end
    check("rgb_valid_out", 24'(rgb_valid), 24'd1);
    check("rgb_value", rgb, 24'(exp_rgb));
    check("req_low_out", 24'(sram_req), 24'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("rgb_held", rgb, 24'(exp_rgb));
      check("rgb_valid_held", 24'(rgb_valid), 24'd1);
      check("pix_ready_out", 24'(pix_ready), 24'd0);
    end
    rgb_ready = 1'b1;
    @(negedge clk);
    rgb_ready = 1'b0;
    check("rgb_valid_drop", 24'(rgb_valid), 24'd0);
    check("pix_ready_back", 24'(pix_ready), 24'd1);
  endtask

  initial begin
    int oid, pidx, dly, rd, hold;
    int ta_idx;
    rst        = 1'b1;
    pix_valid  = 1'b0;
    obj_id     = MAP;
    obj_idx    = '0;
    sram_ack   = 1'b0;
    sram_rdata = '0;
    rgb_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 24'(sram_req), 24'd0);
    check("rst_addr", 24'(sram_addr), 24'd0);
    check("rst_rgb_valid", 24'(rgb_valid), 24'd0);
    check("rst_rgb", rgb, 24'd0);
    check("rst_pix_ready", 24'(pix_ready), 24'd1);
    rst = 1'b0;
    @(negedge clk);

    // Circle: one-cycle latency, no SRAM traffic.
    run_txn(4, 17, 0, 0, 0);
    run_txn(5, 0, 0, 0, 1);
    // Map pixel with 3-cycle ack delay; pure red.
    run_txn(0, 1601, 3, 'hF800, 0);
    // Output held while downstream stalls.
    run_txn(2, 300, 1, 'h07E0, 5);
    run_txn(3, 16383, 0, 'h001F, 0);
    // Unknown IDs give black after a non-black pixel.
    run_txn(1, 5, 2, 'hFFFF, 0);
    run_txn(6, 9, 0, 0, 0);
    run_txn(4, 0, 0, 0, 0);
    run_txn(7, 9, 0, 0, 2);

    for (int n = 0; n < 30; n++) begin
      oid  = int'($urandom_range(7, 0));
      pidx = int'($urandom_range(16383, 0));
      dly  = int'($urandom_range(4, 0));
      rd   = int'($urandom_range(65535, 0));
      hold = int'($urandom_range(2, 0));
      run_txn(oid, pidx, dly, rd, hold);
    end

    // Reset mid-request, then a late ack.
    pix_valid = 1'b1;
    obj_id    = CAR1;
    obj_idx   = 14'd42;
    @(negedge clk);
    pix_valid = 1'b0;
    check("pre_rst_req", 24'(sram_req), 24'd1);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    sram_ack   = 1'b1;
    sram_rdata = 16'hFFFF;
    @(negedge clk);
    sram_ack = 1'b0;
    check("late_ack_req", 24'(sram_req), 24'd0);
    check("late_ack_addr", 24'(sram_addr), 24'd0);
    check("late_ack_rgb_valid", 24'(rgb_valid), 24'd0);
    check("late_ack_rgb", rgb, 24'd0);
    check("late_ack_pix_ready", 24'(pix_ready), 24'd1);
    repeat (3) @(negedge clk);
    check("late_ack_quiet", 24'(rgb_valid), 24'd0);

    // Unacknowledged request: timeout behaviour depends on build.
    run_txn(5, 0, 0, 0, 0);
    ta_idx    = int'($urandom_range(16383, 0));
    pix_valid = 1'b1;
    obj_id    = BAR;
    obj_idx   = ta_idx[13:0];
    @(negedge clk);
    pix_valid = 1'b0;
    for (int n = 1; n <= 255; n++) begin
      check("to_req_held", 24'(sram_req), 24'd1);
      @(negedge clk);
    end
`ifdef PIXEL_FETCHER_TIMEOUT_EN
    check("to_rgb_valid", 24'(rgb_valid), 24'd1);
    check("to_rgb_black", rgb, 24'd0);
    check("to_req_drop", 24'(sram_req), 24'd0);
`else
    check("nto_req_still", 24'(sram_req), 24'd1);
    check("nto_rgb_valid", 24'(rgb_valid), 24'd0);
    sram_ack   = 1'b1;
    sram_rdata = 16'h001F;
    @(negedge clk);
    sram_ack = 1'b0;
    check("nto_rgb_valid_after", 24'(rgb_valid), 24'd1);
    check("nto_rgb", rgb, 24'h0000FF);
`endif
    rgb_ready = 1'b1;
    @(negedge clk);
    rgb_ready = 1'b0;
    check("final_idle", 24'(pix_ready), 24'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
